// File: rtl/amba_ahb_pkg.sv
// Shared AHB encodings, arbiter FSM states and helpers for the AHB bus arbiter.
// Used by amba_ahb_arbiter (optional fixed-priority build: AHB_ARB_FIXED_PRIO_EN).
package amba_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_BURST  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_e;

    // Beats in a fixed-length burst; 0 for SINGLE/INCR, which never freeze the grant.
    function automatic logic [4:0] burst_beats(input logic [2:0] hb);
        logic [4:0] beats;
        case (hb)
            HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
            default:                      beats = 5'd0;
        endcase
        return beats;
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (oh[k]) begin
                idx = 2'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/amba_ahb_arb_picker.sv
// Combinational grant picker: round-robin from (ptr_i + 1), or fixed lowest-index
// priority when AHB_ARB_FIXED_PRIO_EN is defined. No requests -> default master.
module amba_ahb_arb_picker #(
    parameter int DEFAULT_MASTER = 0
) (
    input  logic [3:0] req_i,
`ifndef AHB_ARB_FIXED_PRIO_EN
    input  logic [1:0] ptr_i,
`endif
    output logic [3:0] gnt_o
);

    localparam logic [3:0] DEF_GNT = 4'b0001 << DEFAULT_MASTER;

`ifdef AHB_ARB_FIXED_PRIO_EN

    always_comb begin
        gnt_o = DEF_GNT;
        for (int k = 3; k >= 0; k--) begin
            if (req_i[k]) begin
                gnt_o = 4'b0001 << k;
            end
        end
    end

`else

    logic [3:0] rot_req;
    logic [1:0] rot_idx;
    logic       rot_any;

    // rot_req[0] is the master right after the last grant, so lowest set bit wins.
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
        assign rot_req[gi] = req_i[ptr_i + 2'(gi + 1)];
    end

    always_comb begin
        rot_idx = 2'd0;
        rot_any = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (rot_req[k]) begin
                rot_idx = 2'(k);
                rot_any = 1'b1;
            end
        end
        gnt_o = rot_any ? (4'b0001 << (ptr_i + rot_idx + 2'd1)) : DEF_GNT;
    end

`endif

endmodule

// File: rtl/amba_ahb_arbiter.sv
// Four-master AHB arbiter with burst and locked-transfer grant freezing.
// Define AHB_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module amba_ahb_arbiter
    import amba_ahb_pkg::*;
#(
    parameter int DEFAULT_MASTER = 0
) (
    input  logic       hclk,
    input  logic       hreset,
    input  logic [3:0] hbusreq,
    input  logic [3:0] hlock,
    input  logic [1:0] htrans,
    input  logic [2:0] hburst,
    input  logic       hready,
    output logic [3:0] hgrant,
    output logic [1:0] hmaster,
    output logic       hmastlock
);

    localparam logic [1:0] DM_IDX = 2'(DEFAULT_MASTER);
    localparam logic [3:0] DM_GNT = 4'b0001 << DEFAULT_MASTER;

    arb_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] hgrant_q, hgrant_d;
    logic [1:0] hmaster_q, hmaster_d;
    logic       hmastlock_q, hmastlock_d;
`ifndef AHB_ARB_FIXED_PRIO_EN
    logic [1:0] last_q, last_d;
`endif

    logic [3:0] pick_gnt;
    logic [4:0] beats;
    logic       arb_eval;
    logic       is_nonseq;

    amba_ahb_arb_picker #(
        .DEFAULT_MASTER(DEFAULT_MASTER)
    ) u_picker (
        .req_i (hbusreq),
`ifndef AHB_ARB_FIXED_PRIO_EN
        .ptr_i (last_q),
`endif
        .gnt_o (pick_gnt)
    );

    assign beats     = burst_beats(hburst);
    assign is_nonseq = (htrans == HTRANS_NONSEQ);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hgrant_d    = hgrant_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
`ifndef AHB_ARB_FIXED_PRIO_EN
        last_d      = last_q;
`endif
        arb_eval    = 1'b0;

        if (hready) begin
            hmaster_d = onehot_to_idx(hgrant_q);

            case (state_q)
                ST_ARB: begin
                    arb_eval = 1'b1;
                end
                ST_BURST: begin
                    if (htrans == HTRANS_SEQ) begin
                        cnt_d = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_d = ST_ARB;
                        end
                    end else if (htrans != HTRANS_BUSY) begin
                        // IDLE or NONSEQ cut the burst short; treat the edge as arbitration.
                        arb_eval = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!hlock[hmaster_q]) begin
                        state_d     = ST_ARB;
                        hmastlock_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_ARB;
                end
            endcase

            if (arb_eval) begin
                if (is_nonseq && hlock[hmaster_q]) begin
                    state_d     = ST_LOCKED;
                    hmastlock_d = 1'b1;
                    cnt_d       = 4'd0;
                end else if (is_nonseq && (beats != 5'd0)) begin
                    state_d = ST_BURST;
                    cnt_d   = 4'(beats - 5'd1);
                end else begin
                    state_d  = ST_ARB;
                    cnt_d    = 4'd0;
                    hgrant_d = pick_gnt;
`ifndef AHB_ARB_FIXED_PRIO_EN
                    last_d   = onehot_to_idx(pick_gnt);
`endif
                end
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= ST_ARB;
            cnt_q       <= 4'd0;
            hgrant_q    <= DM_GNT;
            hmaster_q   <= DM_IDX;
            hmastlock_q <= 1'b0;
`ifndef AHB_ARB_FIXED_PRIO_EN
            last_q      <= DM_IDX;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hgrant_q    <= hgrant_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
`ifndef AHB_ARB_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    assign hgrant    = hgrant_q;
    assign hmaster   = hmaster_q;
    assign hmastlock = hmastlock_q;

endmodule
